// File: rtl/uart_rx_frame_ctrl.sv
// UART byte capture FIFO plus SOF/LEN/payload/CSUM frame parser with valid/ready payload output.
// Define RX_TIMEOUT_EN to abort a frame after TIMEOUT_CYC idle cycles.
module uart_rx_frame_ctrl #(
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] SOF_BYTE    = 8'h7E,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rx_rdy_clr,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic [7:0] err_cnt
);
  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_rx_rdy_clr, r_frame_ok, r_frame_err, r_overrun;
  logic [7:0]    r_err_cnt, r_sum, r_rem;
  logic [7:0]    w_sum_nxt, w_rem_nxt, w_head, w_csum;
  logic          w_cap, w_full, w_empty, w_push, w_pop;
  logic          w_ok_nxt, w_err_nxt, w_timeout;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_head  = r_mem[r_rd_ptr];
  // rx_rdy stays high until our clear lands; the registered clear masks that second cycle.
  assign w_cap   = rx_rdy && !r_rx_rdy_clr;
  assign w_pop   = !w_empty && ((r_state != PAYLOAD) || m_ready);
  assign w_push  = w_cap && (!w_full || w_pop);
  assign w_csum  = r_sum + w_head;

  assign rx_rdy_clr = r_rx_rdy_clr;
  assign m_data     = w_head;
  assign m_valid    = (r_state == PAYLOAD) && !w_empty;
  assign m_last     = (r_state == PAYLOAD) && (r_rem == 8'd1);
  assign frame_ok   = r_frame_ok;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign err_cnt    = r_err_cnt;

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;
  logic          w_to_run;

  // Back-pressure with data waiting is the consumer's stall, not an idle link.
  assign w_to_run  = (r_state != HUNT) && !w_pop && !((r_state == PAYLOAD) && !w_empty);
  assign w_timeout = w_to_run && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)                       r_to_cnt <= '0;
    else if (!w_to_run || w_timeout)  r_to_cnt <= '0;
    else                              r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_rem_nxt   = r_rem;
    w_ok_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      HUNT: begin
        if (!w_empty && (w_head == SOF_BYTE)) begin
          w_sum_nxt   = 8'd0;
          w_state_nxt = LEN;
        end
      end
      LEN: begin
        if (!w_empty) begin
          w_sum_nxt = w_head;
          w_rem_nxt = w_head;
          if (w_head == 8'd0) begin
            w_state_nxt = CSUM;
          end else if (w_head > MAX_LEN_B) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = HUNT;
          end else begin
            w_state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (w_pop) begin
          w_sum_nxt = w_csum;
          w_rem_nxt = r_rem - 8'd1;
          if (r_rem == 8'd1) w_state_nxt = CSUM;
        end
      end
      CSUM: begin
        if (!w_empty) begin
          w_ok_nxt    = (w_csum == 8'd0);
          w_err_nxt   = (w_csum != 8'd0);
          w_state_nxt = HUNT;
        end
      end
      default: w_state_nxt = HUNT;
    endcase
    if (w_timeout) begin
      w_ok_nxt    = 1'b0;
      w_err_nxt   = 1'b1;
      w_state_nxt = HUNT;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rx_rdy_clr <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_err_cnt    <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_rx_rdy_clr <= w_cap;
      r_frame_ok   <= w_ok_nxt;
      r_frame_err  <= w_err_nxt;
      if (w_err_nxt) r_err_cnt <= sat_inc8(r_err_cnt);
      if (w_cap && !w_push) r_overrun <= 1'b1;
      else if (ovr_clr)     r_overrun <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage and running sum/count carry no reset; state alone decides whether they matter.
  always_ff @(posedge clk_50m) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_data;
    r_sum <= w_sum_nxt;
    r_rem <= w_rem_nxt;
  end

endmodule
